// File: rtl/rcl_stream.sv
// rcl_stream: pipelined line/circle relation classifier with per-batch class counts.
// Each line a*x + b*y + c = 0 is classified against the stored circle
// (centre (m,n), squared radius k) as separate, tangent, secant or degenerate.
// Stream handshake: valid-only. Every in_valid cycle is accepted (there is no
// ready); in_last is only meaningful together with in_valid. Results leave in
// order, four cycles after acceptance, as single-cycle out_valid pulses.
module rcl_stream #(
  parameter int W     = 5,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             circ_valid,
  input  logic [W-1:0]     circ_m,
  input  logic [W-1:0]     circ_n,
  input  logic [W-1:0]     circ_k,
  input  logic             in_valid,
  input  logic [W-1:0]     coef_a,
  input  logic [W-1:0]     coef_b,
  input  logic [W-1:0]     coef_c,
  input  logic             in_last,
  output logic             out_valid,
  output logic [1:0]       out,
  output logic             out_last,
  output logic             sum_valid,
  output logic [CNT_W-1:0] cnt_sep,
  output logic [CNT_W-1:0] cnt_tan,
  output logic [CNT_W-1:0] cnt_sec,
  output logic [CNT_W-1:0] cnt_deg,
  output logic [1:0]       dbg_state
);

  localparam int PW = 2*W + 2;  // p = a*m + b*n + c
  localparam int QW = 2*W + 1;  // q = a^2 + b^2
  localparam int DW = 4*W + 4;  // d = p^2, also the comparison width
  localparam int RW = 3*W + 1;  // r = q*k
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_RUN = 2'd1, ST_SUM = 2'd2} state_t;

  // Circle registers; a line accepted alongside circ_valid sees the new circle.
  logic signed [W-1:0] m_q, n_q;
  logic        [W-1:0] k_q;
  logic signed [W-1:0] m_sel, n_sel, a_s, b_s, c_s;
  logic        [W-1:0] k_sel;

  assign m_sel = circ_valid ? circ_m : m_q;
  assign n_sel = circ_valid ? circ_n : n_q;
  assign k_sel = circ_valid ? circ_k : k_q;
  assign a_s   = coef_a;
  assign b_s   = coef_b;
  assign c_s   = coef_c;

  // Circle register update.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_q <= '0;
      n_q <= '0;
      k_q <= '0;
    end else if (circ_valid) begin
      m_q <= circ_m;
      n_q <= circ_n;
      k_q <= circ_k;
    end
  end

  // Stage 1: products; circle operands travel with the line from here on.
  logic signed [2*W-1:0] am_d, bn_d, s1_am, s1_bn;
  logic        [2*W-1:0] aa_d, bb_d, s1_aa, s1_bb;
  logic signed [W-1:0]   s1_c;
  logic        [W-1:0]   s1_k;
  logic                  s1_v, s1_last, s1_deg;

  assign am_d = (2*W)'(a_s) * (2*W)'(m_sel);
  assign bn_d = (2*W)'(b_s) * (2*W)'(n_sel);
  assign aa_d = $unsigned((2*W)'(a_s) * (2*W)'(a_s));
  assign bb_d = $unsigned((2*W)'(b_s) * (2*W)'(b_s));

  // Stage 1 register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_v <= 1'b0; s1_last <= 1'b0; s1_deg <= 1'b0;
      s1_am <= '0; s1_bn <= '0; s1_aa <= '0; s1_bb <= '0; s1_c <= '0; s1_k <= '0;
    end else begin
      s1_v    <= in_valid;
      s1_last <= in_valid & in_last;
      s1_deg  <= (coef_a == '0) && (coef_b == '0);
      s1_am   <= am_d;
      s1_bn   <= bn_d;
      s1_aa   <= aa_d;
      s1_bb   <= bb_d;
      s1_c    <= c_s;
      s1_k    <= k_sel;
    end
  end

  // Stage 2: distance numerator p and normal length q.
  logic signed [PW-1:0] p_d, s2_p;
  logic        [QW-1:0] q_d, s2_q;
  logic        [W-1:0]  s2_k;
  logic                 s2_v, s2_last, s2_deg;

  assign p_d = PW'(s1_am) + PW'(s1_bn) + PW'(s1_c);
  assign q_d = QW'(s1_aa) + QW'(s1_bb);

  // Stage 2 register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_v <= 1'b0; s2_last <= 1'b0; s2_deg <= 1'b0;
      s2_p <= '0; s2_q <= '0; s2_k <= '0;
    end else begin
      s2_v <= s1_v; s2_last <= s1_last; s2_deg <= s1_deg;
      s2_p <= p_d;  s2_q <= q_d;        s2_k <= s1_k;
    end
  end

  // Stage 3: squared distance numerator d versus scaled radius r.
  logic [DW-1:0] d_d, s3_d;
  logic [RW-1:0] r_d, s3_r;
  logic          s3_v, s3_last, s3_deg;

  assign d_d = $unsigned(DW'(s2_p) * DW'(s2_p));
  assign r_d = RW'(s2_q) * RW'(s2_k);

  // Stage 3 register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s3_v <= 1'b0; s3_last <= 1'b0; s3_deg <= 1'b0; s3_d <= '0; s3_r <= '0;
    end else begin
      s3_v <= s2_v; s3_last <= s2_last; s3_deg <= s2_deg; s3_d <= d_d; s3_r <= r_d;
    end
  end

  // Stage 4 classification: degenerate overrides the comparison.
  logic [1:0] cls_d;
  always_comb begin
    cls_d = 2'd2;
    if (s3_deg)                  cls_d = 2'd3;
    else if (s3_d > DW'(s3_r))   cls_d = 2'd0;
    else if (s3_d == DW'(s3_r))  cls_d = 2'd1;
  end

  // Stage 4 register drives the result outputs directly.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0; out_last <= 1'b0; out <= '0;
    end else begin
      out_valid <= s3_v; out_last <= s3_last; out <= cls_d;
    end
  end

  // Batch counting: tot_d is the saturating count including this cycle's result.
  logic             batch_end;
  logic [CNT_W-1:0] cnt_q [4];
  logic [CNT_W-1:0] cnt_d [4];
  logic [CNT_W-1:0] tot_d [4];
  logic [CNT_W-1:0] tot_q [4];

  assign batch_end = out_valid & out_last;

  // Next counter values; counters restart when a batch closes.
  always_comb begin
    for (int i = 0; i < 4; i++) begin
      tot_d[i] = cnt_q[i];
      if (out_valid && (out == 2'(i)) && (cnt_q[i] != CNT_MAX))
        tot_d[i] = cnt_q[i] + CNT_W'(1);
      cnt_d[i] = batch_end ? '0 : tot_d[i];
    end
  end

  // Counter and held-summary registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 4; i++) begin
        cnt_q[i] <= '0;
        tot_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < 4; i++) begin
        cnt_q[i] <= cnt_d[i];
        if (batch_end) tot_q[i] <= tot_d[i];
      end
    end
  end

  assign cnt_sep = tot_q[0];
  assign cnt_tan = tot_q[1];
  assign cnt_sec = tot_q[2];
  assign cnt_deg = tot_q[3];

  // Control FSM: IDLE (nothing counted), RUN (batch open), SUM (summary pulse).
  state_t state_q, state_d;

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  // FSM next state.
  always_comb begin
    state_d = state_q;
    if (batch_end)              state_d = ST_SUM;
    else if (out_valid)         state_d = ST_RUN;
    else if (state_q == ST_SUM) state_d = ST_IDLE;
  end

  assign sum_valid = (state_q == ST_SUM);
  assign dbg_state = state_q;

endmodule

// File: tb/tb_rcl_stream.sv
// Testbench for rcl_stream: directed and random lines, scoreboard with a
// behavioural arithmetic model of the classification and batch counts.
module tb_rcl_stream;
  localparam int W     = 5;
  localparam int CNT_W = 2;
  localparam int EW    = 19;            // {due cycle[15:0], class[1:0], last}
  localparam int SW    = 16 + 4*CNT_W;  // {due cycle[15:0], sep, tan, sec, deg}

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             circ_valid = 1'b0;
  logic [W-1:0]     circ_m = '0, circ_n = '0, circ_k = '0;
  logic             in_valid = 1'b0;
  logic [W-1:0]     coef_a = '0, coef_b = '0, coef_c = '0;
  logic             in_last = 1'b0;
  logic             out_valid, out_last, sum_valid;
  logic [1:0]       out, dbg_state;
  logic [CNT_W-1:0] cnt_sep, cnt_tan, cnt_sec, cnt_deg;

  rcl_stream #(.W(W), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .circ_valid(circ_valid), .circ_m(circ_m), .circ_n(circ_n), .circ_k(circ_k),
    .in_valid(in_valid), .coef_a(coef_a), .coef_b(coef_b), .coef_c(coef_c),
    .in_last(in_last),
    .out_valid(out_valid), .out(out), .out_last(out_last),
    .sum_valid(sum_valid),
    .cnt_sep(cnt_sep), .cnt_tan(cnt_tan), .cnt_sec(cnt_sec), .cnt_deg(cnt_deg),
    .dbg_state(dbg_state)
  );

  // Clock and cycle counter.
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Scoreboard state and reference model.
  logic [EW-1:0] exp_q[$];
  logic [SW-1:0] sum_q[$];
  int mm = 0, mn = 0, mk = 0;
  int bc[4] = '{0, 0, 0, 0};
  int n_checks = 0, n_pass = 0;

  task automatic check(input string name, input longint act, input longint exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
  endtask

  // Relation of line to circle from the plain geometric formulas.
  function automatic logic [1:0] classify(input int a, b, c, m, n, k);
    longint p, d, r;
    if (a == 0 && b == 0) return 2'd3;
    p = longint'(a) * m + longint'(b) * n + c;
    d = p * p;
    r = (longint'(a) * a + longint'(b) * b) * k;
    if (d > r)  return 2'd0;
    if (d == r) return 2'd1;
    return 2'd2;
  endfunction

  // Drive one cycle of inputs and record what the DUT must produce.
  task automatic drive(input bit cv, input int m, n, k, input bit iv, input int a, b, c,
                       input bit last);
    logic [1:0]       cls;
    logic [15:0]      due;
    logic [CNT_W-1:0] v0, v1, v2, v3;
    @(posedge clk); #1;
    circ_valid = cv;
    circ_m = m[W-1:0]; circ_n = n[W-1:0]; circ_k = k[W-1:0];
    in_valid = iv;
    coef_a = a[W-1:0]; coef_b = b[W-1:0]; coef_c = c[W-1:0];
    in_last = last;
    if (cv) begin mm = m; mn = n; mk = k; end
    if (iv) begin
      cls = classify(a, b, c, mm, mn, mk);
      due = 16'(cyc + 4);
      exp_q.push_back({due, cls, last});
      if (bc[cls] < (1 << CNT_W) - 1) bc[cls] = bc[cls] + 1;
      if (last) begin
        due = 16'(cyc + 5);
        v0 = bc[0][CNT_W-1:0]; v1 = bc[1][CNT_W-1:0];
        v2 = bc[2][CNT_W-1:0]; v3 = bc[3][CNT_W-1:0];
        sum_q.push_back({due, v0, v1, v2, v3});
        bc = '{0, 0, 0, 0};
      end
    end
  endtask

  task automatic line(input int a, b, c, input bit last);
    drive(1'b0, 0, 0, 0, 1'b1, a, b, c, last);
  endtask

  task automatic circle(input int m, n, k);
    drive(1'b1, m, n, k, 1'b0, 0, 0, 0, 1'b0);
  endtask

  task automatic idle(input int cycles);
    for (int i = 0; i < cycles; i++)
      drive(1'b0, 0, 0, 0, 1'b0, 0, 0, 0, 1'($urandom_range(0, 1)));
  endtask

  // Mid-stream reset: in-flight work and the open batch are forgotten.
  task automatic pulse_reset();
    @(posedge clk); #1;
    in_valid = 1'b0; circ_valid = 1'b0; in_last = 1'b0;
    rst_n = 1'b0;
    exp_q.delete(); sum_q.delete();
    bc = '{0, 0, 0, 0};
    mm = 0; mn = 0; mk = 0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  // Monitor: compare DUT outputs against the expected queues every cycle.
  always @(negedge clk) begin
    logic [EW-1:0] e;
    logic [SW-1:0] s;
    if (exp_q.size() > 0 && exp_q[0][EW-1:3] == cyc[15:0]) begin
      e = exp_q.pop_front();
      check("out_valid", longint'(out_valid), 1);
      check("out_class", longint'(out), longint'(e[2:1]));
      check("out_last", longint'(out_last), longint'(e[0]));
    end else if (out_valid) begin
      check("spurious_out_valid", longint'(out_valid), 0);
    end
    if (sum_q.size() > 0 && sum_q[0][SW-1:4*CNT_W] == cyc[15:0]) begin
      s = sum_q.pop_front();
      check("sum_valid", longint'(sum_valid), 1);
      check("cnt_sep", longint'(cnt_sep), longint'(s[4*CNT_W-1:3*CNT_W]));
      check("cnt_tan", longint'(cnt_tan), longint'(s[3*CNT_W-1:2*CNT_W]));
      check("cnt_sec", longint'(cnt_sec), longint'(s[2*CNT_W-1:CNT_W]));
      check("cnt_deg", longint'(cnt_deg), longint'(s[CNT_W-1:0]));
    end else if (sum_valid) begin
      check("spurious_sum_valid", longint'(sum_valid), 0);
    end
  end

  // Main stimulus sequence.
  initial begin
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    check("rst_out_valid", longint'(out_valid), 0);
    check("rst_out", longint'(out), 0);
    check("rst_out_last", longint'(out_last), 0);
    check("rst_sum_valid", longint'(sum_valid), 0);
    check("rst_cnt_sep", longint'(cnt_sep), 0);
    check("rst_cnt_sec", longint'(cnt_sec), 0);
    check("rst_state", longint'(dbg_state), 0);

    // Tangent, separate, secant on separate cycles.
    circle(0, 0, 4);
    line(1, 0, -2, 1'b0); idle(5);
    line(1, 0, -3, 1'b0); idle(5);
    line(1, 0, -1, 1'b1); idle(6);

    // Same three back to back as one batch.
    line(1, 0, -2, 1'b0); line(1, 0, -3, 1'b0); line(1, 0, -1, 1'b1);
    idle(6);

    // Degenerate lines.
    line(0, 0, 0, 1'b0); line(0, 0, 5, 1'b1);
    idle(6);

    // Width extremes and the zero circle.
    circle(-16, -16, 31);
    line(-16, -16, -16, 1'b1);
    circle(0, 0, 0);
    line(1, 1, 0, 1'b1);
    idle(6);

    // Circle changes between two identical lines.
    circle(0, 0, 4);
    line(1, 0, -2, 1'b0);
    drive(1'b1, 0, 0, 9, 1'b1, 1, 0, -2, 1'b1);
    idle(6);

    // Saturation: five secant lines in one batch.
    for (int i = 0; i < 5; i++) line(1, 0, -2, i == 4);
    idle(6);

    // Back-to-back batches of one line each.
    line(1, 0, -3, 1'b1); line(1, 0, -2, 1'b1); line(0, 0, 1, 1'b1);
    idle(6);

    // Randomised traffic.
    for (int i = 0; i < 400; i++) begin
      bit cv, iv, lst;
      cv  = ($urandom_range(0, 9) == 0);
      iv  = ($urandom_range(0, 9) < 7);
      lst = ($urandom_range(0, 3) == 0);
      if ($urandom_range(0, 1) == 1)
        drive(cv, $urandom_range(0, 4) - 2, $urandom_range(0, 4) - 2, $urandom_range(0, 31),
              iv, $urandom_range(0, 6) - 3, $urandom_range(0, 6) - 3,
              $urandom_range(0, 15) - 8, lst);
      else
        drive(cv, $urandom_range(0, 31) - 16, $urandom_range(0, 31) - 16,
              $urandom_range(0, 31), iv, $urandom_range(0, 31) - 16,
              $urandom_range(0, 31) - 16, $urandom_range(0, 31) - 16, lst);
    end
    line(1, 1, 1, 1'b1);
    idle(8);

    // Reset with three lines in flight.
    circle(0, 0, 4);
    line(1, 0, -2, 1'b0); line(1, 0, -3, 1'b0); line(1, 0, -1, 1'b1);
    pulse_reset();
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      check("post_reset_out_valid", longint'(out_valid), 0);
      check("post_reset_sum_valid", longint'(sum_valid), 0);
    end

    // Traffic after reset, circle back at zero.
    line(1, 0, 0, 1'b0); line(0, 1, 1, 1'b1);
    idle(8);

    check("exp_q_drained", longint'(exp_q.size()), 0);
    check("sum_q_drained", longint'(sum_q.size()), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
